// File: rtl/memio_pkg.sv
// Shared encodings for the MEM-stage load/store router: funct3 codes,
// IO window offsets, decode struct and IO-load FSM states.
package memio_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [7:0] IN_OFS      = 8'h00;
  localparam logic [7:0] OUT_OFS     = 8'h40;
  localparam logic [7:0] BTN_OFS_DEF = 8'h80;

  typedef enum logic {IDLE, IO_RD} state_e;

  typedef struct packed {
    logic       in_hit;
    logic       out_hit;
    logic       btn_hit;
    logic       unmapped;
    logic [3:0] idx;
  } io_dec_t;

endpackage

// File: rtl/memio_lane_align.sv
// Byte-lane steering: store byte enables / data replication and
// load lane extraction with sign or zero extension.
module memio_lane_align
  import memio_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      SB[1:0]: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SH[1:0]: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SW[1:0]: be = 4'b1111;
      default: be = 4'b1111;
    endcase
  end

  // Misaligned halves use addr[1] only; addr[0] is not looked at here.
  assign byte_l = rdata[{addr_lo, 3'b000} +: 8];
  assign half_l = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      LB:      load_val = {{24{byte_l[7]}}, byte_l};
      LH:      load_val = {{16{half_l[15]}}, half_l};
      LBU:     load_val = {24'b0, byte_l};
      LHU:     load_val = {16'b0, half_l};
      LW:      load_val = rdata;
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/mem_io_bridge.sv
// MEM-stage router between data memory and memory-mapped IO channels.
// Optional access checking is enabled by defining MEMIO_ERR_CHECK_EN.
module mem_io_bridge
  import memio_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int          N_IN    = 4,
  parameter int          N_OUT   = 4,
  parameter logic [7:0]  BTN_OFS = BTN_OFS_DEF,
  parameter int          IN_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  input  logic [31:0]           dmem_rdata,
  input  logic [N_IN*IN_W-1:0]  in_data,
  input  logic                  btn_raw,
  output logic [31:0]           dmem_addr,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic [N_OUT*32-1:0]   out_data,
  output logic [N_OUT-1:0]      out_strobe,
  output logic                  btn_pending,
  output logic                  err_valid,
  output logic [31:0]           err_addr
);

  logic [7:0]  ofs;
  logic        io_sel, rd_req, io_rd_go, out_wr, err_now;
  logic        btn_raw_q, btn_rise, btn_clr;
  logic [31:0] in_word, out_word, io_rd_val, rd_q, mem_ld;
  io_dec_t     dec;
  state_e      state;
  logic [N_OUT-1:0][31:0] out_q;
  logic [N_OUT-1:0]       strobe_q;

  assign ofs    = addr[7:0];
  assign io_sel = (addr[31:8] == IO_BASE[31:8]);
  // A write alongside a read wins; the read is treated as absent.
  assign rd_req = mem_read & ~mem_write;

  always_comb begin
    dec      = '0;
    in_word  = '0;
    out_word = '0;
    for (int k = 0; k < N_IN; k++)
      if (ofs == IN_OFS + 8'(4*k)) begin
        dec.in_hit = 1'b1;
        in_word    = 32'(in_data[k*IN_W +: IN_W]);
      end
    for (int k = 0; k < N_OUT; k++)
      if (ofs == OUT_OFS + 8'(4*k)) begin
        dec.out_hit = 1'b1;
        dec.idx     = 4'(k);
        out_word    = out_q[k];
      end
    dec.btn_hit  = (ofs == BTN_OFS);
    dec.unmapped = ~(dec.in_hit | dec.out_hit | dec.btn_hit);
  end

  // An edge arriving in the capture cycle is reported now and stays pending.
  assign btn_rise  = btn_raw & ~btn_raw_q;
  assign io_rd_val = dec.in_hit  ? in_word :
                     dec.out_hit ? out_word :
                     dec.btn_hit ? {31'b0, btn_pending | btn_rise} : 32'b0;

`ifdef MEMIO_ERR_CHECK_EN
  logic misal;
  assign misal   = (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1] & |addr[1:0]) |
                   (io_sel & |addr[1:0]);
  assign err_now = (mem_read | mem_write) & (misal | (io_sel & dec.unmapped));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (err_now && !err_valid) begin
      err_valid <= 1'b1;
      err_addr  <= addr;
    end
`else
  assign err_now   = 1'b0;
  assign err_valid = 1'b0;
  assign err_addr  = '0;
`endif

  memio_lane_align u_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_val   (mem_ld)
  );

  assign dmem_addr = {addr[31:2], 2'b00};
  assign dmem_we   = mem_write & ~io_sel & ~err_now;

  assign io_rd_go  = rd_req & io_sel & (state == IDLE);
  assign stall     = io_rd_go & rst_n;
  assign btn_clr   = io_rd_go & dec.btn_hit;
  assign load_data = (state == IO_RD)     ? rd_q :
                     (rd_req & ~io_sel)   ? mem_ld : 32'b0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      rd_q        <= '0;
      btn_raw_q   <= 1'b0;
      btn_pending <= 1'b0;
    end else begin
      state       <= io_rd_go ? IO_RD : IDLE;
      if (io_rd_go) rd_q <= io_rd_val;
      btn_raw_q   <= btn_raw;
      btn_pending <= btn_rise | (btn_pending & ~btn_clr);
    end

  assign out_wr = mem_write & io_sel & dec.out_hit & ~err_now;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_q    <= '0;
      strobe_q <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        strobe_q[k] <= out_wr & (dec.idx == 4'(k));
        if (out_wr && dec.idx == 4'(k)) out_q[k] <= store_data;
      end
    end

  assign out_data   = out_q;
  assign out_strobe = strobe_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed cases plus randomized
// traffic against a transaction-level reference model.
module tb_mem_io_bridge;

  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int IN_W  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 mem_read = 1'b0, mem_write = 1'b0, btn_raw = 1'b0;
  logic [2:0]           funct3 = '0;
  logic [31:0]          addr = '0, store_data = '0, dmem_rdata = '0;
  logic [N_IN*IN_W-1:0] in_data = '0;
  logic [31:0]          dmem_addr, dmem_wdata, load_data, err_addr;
  logic                 dmem_we, stall, btn_pending, err_valid;
  logic [3:0]           dmem_be;
  logic [N_OUT*32-1:0]  out_data;
  logic [N_OUT-1:0]     out_strobe;

  mem_io_bridge #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .dmem_rdata(dmem_rdata),
    .in_data(in_data), .btn_raw(btn_raw), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .load_data(load_data), .stall(stall),
    .out_data(out_data), .out_strobe(out_strobe), .btn_pending(btn_pending),
    .err_valid(err_valid), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0]          m_out [N_OUT];
  logic [N_OUT-1:0]     m_strobe;
  logic                 m_btn, m_btn_prev, m_pend, m_err;
  logic [31:0]          m_pend_val, m_err_addr;
  logic [N_IN*IN_W-1:0] nxt_in = '0;
  logic                 nxt_btn = 1'b0;

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    m_strobe = '0; m_btn = 0; m_btn_prev = 0; m_pend = 0; m_pend_val = '0;
    m_err = 0; m_err_addr = '0;
  endtask

  function automatic logic is_io(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFC;
  endfunction

  function automatic int in_ch(input logic [31:0] a);
    int o = int'(a[7:0]);
    if (is_io(a) && o % 4 == 0 && o < 4*N_IN) return o / 4;
    return -1;
  endfunction

  function automatic int out_ch(input logic [31:0] a);
    int o = int'(a[7:0]);
    if (is_io(a) && o % 4 == 0 && o >= 64 && o < 64 + 4*N_OUT) return (o - 64) / 4;
    return -1;
  endfunction

  function automatic logic io_unmapped(input logic [31:0] a);
    return in_ch(a) < 0 && out_ch(a) < 0 && a[7:0] != 8'h80;
  endfunction

  function automatic logic [31:0] mem_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (int'(a[1:0]) * 8)) & 32'hFF;
    h = a[1] ? (d >> 16) : (d & 32'hFFFF);
    case (f)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] io_read(input logic [31:0] a, input logic rise);
    int c;
    c = in_ch(a);
    if (c >= 0) return 32'((in_data >> (c * IN_W)) & 64'hFFFF);
    c = out_ch(a);
    if (c >= 0) return m_out[c];
    if (is_io(a) && a[7:0] == 8'h80) return {31'b0, m_btn | rise};
    return '0;
  endfunction

  function automatic logic err_now_f();
`ifdef MEMIO_ERR_CHECK_EN
    logic mis;
    if (!(mem_read || mem_write)) return 1'b0;
    mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1] && addr[1:0] != 2'b00) ||
          (is_io(addr) && addr[1:0] != 2'b00);
    return mis || (is_io(addr) && io_unmapped(addr));
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_model();
    logic        rd, es;
    logic [31:0] el, ew;
    logic [3:0]  ebe;
    rd = mem_read && !mem_write;
    es = 0; el = '0;
    if (m_pend) el = m_pend_val;
    else if (rd && is_io(addr)) es = 1;
    else if (rd) el = mem_load(funct3, addr, dmem_rdata);
    case (funct3[1:0])
      2'b00:   begin ebe = 4'(1 << int'(addr[1:0])); ew = (store_data & 32'hFF) * 32'h01010101; end
      2'b01:   begin ebe = addr[1] ? 4'hC : 4'h3;    ew = (store_data & 32'hFFFF) * 32'h00010001; end
      default: begin ebe = 4'hF;                     ew = store_data; end
    endcase
    chk("stall", 32'(stall), 32'(es));
    chk("load_data", load_data, el);
    chk("dmem_we", 32'(dmem_we), 32'(mem_write && !is_io(addr) && !err_now_f()));
    chk("dmem_addr", dmem_addr, addr & 32'hFFFFFFFC);
    chk("dmem_be", 32'(dmem_be), 32'(ebe));
    chk("dmem_wdata", dmem_wdata, ew);
    chk("out_strobe", 32'(out_strobe), 32'(m_strobe));
    for (int k = 0; k < N_OUT; k++) chk("out_data", out_data[32*k +: 32], m_out[k]);
    chk("btn_pending", 32'(btn_pending), 32'(m_btn));
    chk("err_valid", 32'(err_valid), 32'(m_err));
    chk("err_addr", err_addr, m_err_addr);
  endtask

  task automatic model_update();
    logic rd, rise, en, clr;
    int   k;
    rd   = mem_read && !mem_write;
    rise = btn_raw && !m_btn_prev;
    en   = err_now_f();
    clr  = 0;
    m_strobe = '0;
    k = out_ch(addr);
    if (mem_write && k >= 0 && !en) begin m_out[k] = store_data; m_strobe[k] = 1'b1; end
    if (m_pend) m_pend = 0;
    else if (rd && is_io(addr)) begin
      m_pend     = 1;
      m_pend_val = io_read(addr, rise);
      clr        = (addr[7:0] == 8'h80);
    end
    m_btn      = rise || (m_btn && !clr);
    m_btn_prev = btn_raw;
    if (en && !m_err) begin m_err = 1; m_err_addr = addr; end
  endtask

  task automatic apply(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rw);
    @(posedge clk);
    model_update();
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    store_data = sd; dmem_rdata = rw; in_data = nxt_in; btn_raw = nxt_btn;
    #1 check_model();
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
  endtask

  int stall_cnt;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_strobe", 32'(out_strobe), 32'h0);
    chk("rst_out0", out_data[31:0], 32'h0);
    chk("rst_btn", 32'(btn_pending), 32'h0);
    chk("rst_err", 32'(err_valid), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Memory lane steering
    apply(1'b0, 1'b1, 3'b010, 32'h100, 32'h12345678, 32'h0);
    chk("sw_be", 32'(dmem_be), 32'hF);
    chk("sw_we", 32'(dmem_we), 32'h1);
    apply(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h12345678);
    chk("lb_101", load_data, 32'h00000056);
    apply(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h12345678);
    chk("lhu_102", load_data, 32'h00001234);
    apply(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0);
    chk("sb_be", 32'(dmem_be), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    apply(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 32'h000000F0);
    chk("lb_sext", load_data, 32'hFFFFFFF0);
    apply(1'b1, 1'b0, 3'b100, 32'h200, 32'h0, 32'h000000F0);
    chk("lbu_zext", load_data, 32'h000000F0);
    chk("mem_ld_stall", 32'(stall), 32'h0);

    // IO input load
    nxt_in = 64'h0000_0ABC_0000_0000;
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC08, 32'h0, 32'h0);
    chk("io_ld_stall", 32'(stall), 32'h1);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC08, 32'h0, 32'h0);
    chk("io_ld_stall2", 32'(stall), 32'h0);
    chk("io_ld_data", load_data, 32'h00000ABC);
    stall_cnt = 0;
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC00, 32'h0, 32'h0); stall_cnt += int'(stall);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC00, 32'h0, 32'h0); stall_cnt += int'(stall);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC04, 32'h0, 32'h0); stall_cnt += int'(stall);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC04, 32'h0, 32'h0); stall_cnt += int'(stall);
    chk("b2b_stalls", 32'(stall_cnt), 32'd2);

    // IO output store
    apply(1'b0, 1'b1, 3'b010, 32'hFFFFFC44, 32'h0000DEAD, 32'h0);
    chk("io_st_we", 32'(dmem_we), 32'h0);
    idle();
    chk("io_st_strobe", 32'(out_strobe), 32'h2);
    chk("io_st_data", out_data[63:32], 32'h0000DEAD);
    idle();
    chk("io_st_strobe_end", 32'(out_strobe), 32'h0);
    chk("io_st_hold", out_data[63:32], 32'h0000DEAD);

    // Button
    nxt_btn = 1'b1; idle();
    nxt_btn = 1'b0; idle();
    chk("btn_set", 32'(btn_pending), 32'h1);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC80, 32'h0, 32'h0);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC80, 32'h0, 32'h0);
    chk("btn_rd", load_data, 32'h1);
    chk("btn_clr", 32'(btn_pending), 32'h0);
    nxt_btn = 1'b1;
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC80, 32'h0, 32'h0);
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC80, 32'h0, 32'h0);
    chk("btn_coinc_rd", load_data, 32'h1);
    chk("btn_coinc_keep", 32'(btn_pending), 32'h1);
    nxt_btn = 1'b0; idle();

`ifdef MEMIO_ERR_CHECK_EN
    apply(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0);
    idle();
    chk("err_set", 32'(err_valid), 32'h1);
    chk("err_addr_first", err_addr, 32'h102);
    apply(1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 32'h0);
    idle();
    chk("err_addr_keep", err_addr, 32'h102);
`endif

    // Asynchronous reset while in IO_RD
    apply(1'b1, 1'b0, 3'b010, 32'hFFFFFC08, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_rst_iord", load_data, 32'h00000ABC);
    rst_n = 1'b0;
    #1;
    chk("rst_iord_stall", 32'(stall), 32'h0);
    chk("rst_iord_load", load_data, 32'h0);
    chk("rst_iord_out", out_data[63:32], 32'h0);
    model_reset();
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; btn_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    begin
      logic        r_rd, r_wr;
      logic [2:0]  r_f3;
      logic [31:0] r_a;
      logic [2:0]  f3_tab [5];
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      r_rd = 0; r_wr = 0; r_f3 = '0; r_a = '0;
      for (int i = 0; i < 600; i++) begin
        logic hold;
        hold = !m_pend && mem_read && !mem_write && is_io(addr);
        if (!hold) begin
          int op, cls;
          op  = int'($urandom_range(0, 9));
          r_rd = (op >= 2 && op <= 5) || op == 9;
          r_wr = (op >= 6);
          r_f3 = f3_tab[$urandom_range(0, 4)];
          cls = int'($urandom_range(0, 5));
          case (cls)
            0, 1: r_a = $urandom_range(0, 32'h000FFFFF);
            2:    r_a = 32'hFFFFFC00 + 32'(4 * $urandom_range(0, 15));
            3:    r_a = 32'hFFFFFC40 + 32'(4 * $urandom_range(0, 5));
            4:    r_a = 32'hFFFFFC80;
            default: r_a = 32'hFFFFFC00 | 32'($urandom_range(0, 255));
          endcase
        end
        nxt_in = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) nxt_btn = ~nxt_btn;
        apply(r_rd, r_wr, r_f3, r_a, $urandom, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
